// File: rtl/motor_cmd_sched.sv
// motor_cmd_sched
// Command scheduler placed in front of the dual-channel PWM/H-bridge driver.
//   - Arbitrates speed commands from the host link and the override source
//     (override wins when both are valid in the same cycle).
//   - Slew-limits each channel and forces a zero dwell on direction reversal.
//   - Produces the driver keep-alive strobe, runs a command watchdog and
//     handles a level-sensitive emergency stop.
//
// Handshake: a command is accepted on a rising clk_16mhz edge where
// valid && ready. Ready depends only on estop and ovr_valid, never on the
// command contents. Targets load on the accept edge.
//
// Ports:
//   clk_16mhz, rst_n              clock, asynchronous active-low reset
//   host_valid/ready/speedA/B     host command channel (signed targets)
//   ovr_valid/ready/speedA/B      override command channel (signed targets)
//   estop                         level emergency stop
//   speedA, speedB                ramped signed speeds to the driver
//   aliveStrobe                   keep-alive toggle to the driver
//   ramping                       a channel is off target or in DWELL
//   timeout                       watchdog tripped / no command since reset
//   src_ovr                       source of last accepted command (1 = override)
//   dbg_chan_dwell                channel FSM state, bit0 = A, bit1 = B (1 = DWELL)
module motor_cmd_sched #(
  parameter int RAMP_DIV      = 16000,
  parameter int STEP          = 4,
  parameter int DWELL_TICKS   = 50,
  parameter int TIMEOUT_TICKS = 250
) (
  input  logic              clk_16mhz,
  input  logic              rst_n,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic signed [7:0] host_speedA,
  input  logic signed [7:0] host_speedB,
  input  logic              ovr_valid,
  output logic              ovr_ready,
  input  logic signed [7:0] ovr_speedA,
  input  logic signed [7:0] ovr_speedB,
  input  logic              estop,
  output logic signed [7:0] speedA,
  output logic signed [7:0] speedB,
  output logic              aliveStrobe,
  output logic              ramping,
  output logic              timeout,
  output logic              src_ovr,
  output logic [1:0]        dbg_chan_dwell
);

  typedef enum logic {ST_RUN = 1'b0, ST_DWELL = 1'b1} chan_state_t;

  typedef struct packed {
    logic signed [7:0] speed;
    chan_state_t       state;
    logic [7:0]        dwell;
  } chan_t;

  localparam chan_t             CHAN_RST = '{speed: 8'sd0, state: ST_RUN, dwell: 8'd0};
  localparam logic signed [8:0] STEP9    = 9'(STEP);
  localparam logic [7:0]        DWELL8   = 8'(DWELL_TICKS);

  // -128 has no positive mirror, so it is pulled in to -127.
  function automatic logic signed [7:0] clamp_cmd(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh81 : v;
  endfunction

  // One ramp-tick update of a channel toward its target.
  function automatic chan_t chan_step(input chan_t c, input logic signed [7:0] tgt);
    logic signed [8:0] cur9;
    logic signed [8:0] tgt9;
    logic signed [8:0] diff;
    logic signed [8:0] mag;
    logic signed [8:0] stp;
    logic              opp;
    chan_step = c;
    cur9 = {c.speed[7], c.speed};
    tgt9 = {tgt[7], tgt};
    diff = tgt9 - cur9;
    opp  = (c.speed != 8'sd0) && (tgt != 8'sd0) && (c.speed[7] != tgt[7]);
    mag  = 9'sd0;
    stp  = 9'sd0;
    if (c.state == ST_DWELL) begin
      chan_step.speed = 8'sd0;
      if (c.dwell <= 8'd1) begin
        chan_step.state = ST_RUN;
        chan_step.dwell = 8'd0;
      end else begin
        chan_step.dwell = c.dwell - 8'd1;
      end
    end else if (opp) begin
      // Reversal: head for zero first, never straight across it.
      mag = c.speed[7] ? -cur9 : cur9;
      stp = (mag > STEP9) ? STEP9 : mag;
      chan_step.speed = c.speed[7] ? 8'(cur9 + stp) : 8'(cur9 - stp);
      if ((chan_step.speed == 8'sd0) && (DWELL_TICKS != 0)) begin
        chan_step.state = ST_DWELL;
        chan_step.dwell = DWELL8;
      end
    end else begin
      mag = diff[8] ? -diff : diff;
      stp = (mag > STEP9) ? STEP9 : mag;
      chan_step.speed = diff[8] ? 8'(cur9 - stp) : 8'(cur9 + stp);
    end
  endfunction

  logic [15:0]       r_div;
  logic [15:0]       r_wd;
  logic              r_timeout;
  logic              r_src_ovr;
  logic              r_alive;
  chan_t             r_chan_a;
  chan_t             r_chan_b;
  logic signed [7:0] r_target_a;
  logic signed [7:0] r_target_b;

  logic              w_tick;
  logic [16:0]       w_wd_inc;
  logic              w_ovr_acc;
  logic              w_host_acc;
  logic              w_accept;
  logic signed [7:0] w_cmd_a;
  logic signed [7:0] w_cmd_b;
  logic              w_alive_ok;

  assign ovr_ready  = !estop;
  assign host_ready = !estop && !ovr_valid;
  assign w_ovr_acc  = ovr_valid && ovr_ready;
  assign w_host_acc = host_valid && host_ready;
  assign w_accept   = w_ovr_acc || w_host_acc;
  assign w_cmd_a    = w_ovr_acc ? ovr_speedA : host_speedA;
  assign w_cmd_b    = w_ovr_acc ? ovr_speedB : host_speedB;

  assign w_tick   = (r_div == 16'(RAMP_DIV - 1));
  assign w_wd_inc = {1'b0, r_wd} + 17'd1;

  // Keep toggling after a watchdog trip only while a channel is still winding down.
  assign w_alive_ok = !estop &&
                      (!r_timeout || (r_chan_a.speed != 8'sd0) || (r_chan_b.speed != 8'sd0));

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= 16'd0;
      r_wd       <= 16'd0;
      r_timeout  <= 1'b1;
      r_src_ovr  <= 1'b0;
      r_alive    <= 1'b0;
      r_chan_a   <= CHAN_RST;
      r_chan_b   <= CHAN_RST;
      r_target_a <= 8'sd0;
      r_target_b <= 8'sd0;
    end else begin
      r_div <= w_tick ? 16'd0 : r_div + 16'd1;

      // Channels see the targets held before this edge, so a command accepted
      // on a tick cycle takes effect on the following tick.
      if (w_tick) begin
        r_chan_a <= chan_step(r_chan_a, r_target_a);
        r_chan_b <= chan_step(r_chan_b, r_target_b);
        if (w_alive_ok) begin
          r_alive <= ~r_alive;
        end
      end

      if (w_accept) begin
        r_target_a <= clamp_cmd(w_cmd_a);
        r_target_b <= clamp_cmd(w_cmd_b);
        r_src_ovr  <= w_ovr_acc;
        r_timeout  <= 1'b0;
        r_wd       <= 16'd0;
      end else if (w_tick && !r_timeout) begin
        if (w_wd_inc == 17'(TIMEOUT_TICKS)) begin
          r_timeout  <= 1'b1;
          r_wd       <= 16'd0;
          r_target_a <= 8'sd0;
          r_target_b <= 8'sd0;
        end else begin
          r_wd <= w_wd_inc[15:0];
        end
      end

      // Emergency stop overrides everything above except the watchdog state.
      if (estop) begin
        r_chan_a   <= CHAN_RST;
        r_chan_b   <= CHAN_RST;
        r_target_a <= 8'sd0;
        r_target_b <= 8'sd0;
      end
    end
  end

  assign speedA         = r_chan_a.speed;
  assign speedB         = r_chan_b.speed;
  assign aliveStrobe    = r_alive;
  assign timeout        = r_timeout;
  assign src_ovr        = r_src_ovr;
  assign dbg_chan_dwell = {r_chan_b.state == ST_DWELL, r_chan_a.state == ST_DWELL};
  assign ramping        = (r_chan_a.speed != r_target_a) || (r_chan_b.speed != r_target_b) ||
                          (r_chan_a.state == ST_DWELL) || (r_chan_b.state == ST_DWELL);

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Testbench for motor_cmd_sched: directed scenarios followed by randomized
// traffic. A reference model advances once per clock, pushes the expected
// outputs into exp_q, and a monitor pops and compares on each falling edge.
module tb_motor_cmd_sched;

  localparam int RAMP_DIV = 4;
  localparam int STEP     = 4;
  localparam int DWELL    = 2;
  localparam int TMO      = 10;
  localparam int EW       = 22;

  logic              clk_16mhz = 1'b0;
  logic              rst_n;
  logic              host_valid;
  logic              host_ready;
  logic signed [7:0] host_speedA;
  logic signed [7:0] host_speedB;
  logic              ovr_valid;
  logic              ovr_ready;
  logic signed [7:0] ovr_speedA;
  logic signed [7:0] ovr_speedB;
  logic              estop;
  logic signed [7:0] speedA;
  logic signed [7:0] speedB;
  logic              aliveStrobe;
  logic              ramping;
  logic              timeout;
  logic              src_ovr;
  logic [1:0]        dbg_chan_dwell;

  motor_cmd_sched #(
    .RAMP_DIV(RAMP_DIV), .STEP(STEP), .DWELL_TICKS(DWELL), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk_16mhz(clk_16mhz), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_speedA(host_speedA), .host_speedB(host_speedB),
    .ovr_valid(ovr_valid), .ovr_ready(ovr_ready),
    .ovr_speedA(ovr_speedA), .ovr_speedB(ovr_speedB),
    .estop(estop), .speedA(speedA), .speedB(speedB),
    .aliveStrobe(aliveStrobe), .ramping(ramping), .timeout(timeout),
    .src_ovr(src_ovr), .dbg_chan_dwell(dbg_chan_dwell)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_16mhz = ~clk_16mhz;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cur[2];
  int m_tgt[2];
  int m_dl[2];     // remaining dwell ticks, >0 means the channel is dwelling
  int m_div;
  int m_wd;
  bit m_tmo;
  bit m_src;
  bit m_alive;
  bit m_tick;
  bit m_acc_o;
  bit m_acc_h;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clamp_cmd(input logic signed [7:0] v);
    int x;
    x = int'(v);
    return (x == -128) ? -127 : x;
  endfunction

  function automatic logic [EW-1:0] exp_now();
    logic ramp;
    logic [7:0] a;
    logic [7:0] b;
    ramp = (m_cur[0] != m_tgt[0]) || (m_cur[1] != m_tgt[1]) || (m_dl[0] > 0) || (m_dl[1] > 0);
    a = 8'(m_cur[0]);
    b = 8'(m_cur[1]);
    return {m_dl[1] > 0, m_dl[0] > 0, a, b, m_alive, ramp, m_tmo, m_src};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cur[i] = 0;
      m_tgt[i] = 0;
      m_dl[i]  = 0;
    end
    m_div = 0; m_wd = 0; m_tmo = 1'b1; m_src = 1'b0; m_alive = 1'b0;
  endtask

  task automatic model_chan(input int i);
    int d;
    if (m_dl[i] > 0) begin
      m_dl[i]--;
    end else if (m_cur[i] != 0 && m_tgt[i] != 0 && ((m_cur[i] > 0) != (m_tgt[i] > 0))) begin
      d = min_i(STEP, (m_cur[i] > 0) ? m_cur[i] : -m_cur[i]);
      m_cur[i] = (m_cur[i] > 0) ? m_cur[i] - d : m_cur[i] + d;
      if (m_cur[i] == 0) m_dl[i] = DWELL;
    end else begin
      d = m_tgt[i] - m_cur[i];
      if (d > 0) m_cur[i] = m_cur[i] + min_i(STEP, d);
      else       m_cur[i] = m_cur[i] - min_i(STEP, -d);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_16mhz or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(exp_now());
      end else begin
        m_tick  = (m_div == RAMP_DIV - 1);
        m_div   = m_tick ? 0 : m_div + 1;
        m_acc_o = ovr_valid && !estop;
        m_acc_h = host_valid && !ovr_valid && !estop;
        if (m_tick && !estop && (!m_tmo || m_cur[0] != 0 || m_cur[1] != 0)) m_alive = !m_alive;
        if (m_tick) begin
          model_chan(0);
          model_chan(1);
        end
        if (m_acc_o) begin
          m_tgt[0] = clamp_cmd(ovr_speedA);
          m_tgt[1] = clamp_cmd(ovr_speedB);
        end else if (m_acc_h) begin
          m_tgt[0] = clamp_cmd(host_speedA);
          m_tgt[1] = clamp_cmd(host_speedB);
        end
        if (m_acc_o || m_acc_h) begin
          m_src = m_acc_o; m_tmo = 1'b0; m_wd = 0;
        end else if (m_tick && !m_tmo) begin
          m_wd++;
          if (m_wd == TMO) begin
            m_tmo = 1'b1; m_wd = 0; m_tgt[0] = 0; m_tgt[1] = 0;
          end
        end
        if (estop) begin
          for (int i = 0; i < 2; i++) begin
            m_cur[i] = 0; m_tgt[i] = 0; m_dl[i] = 0;
          end
        end
        exp_q.push_back(exp_now());
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk_16mhz);
      chk("ovr_ready", int'(ovr_ready), int'(!estop));
      chk("host_ready", int'(host_ready), int'(!estop && !ovr_valid));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("speedA", int'(speedA), int'($signed(e[19:12])));
        chk("speedB", int'(speedB), int'($signed(e[11:4])));
        chk("aliveStrobe", int'(aliveStrobe), int'(e[3]));
        chk("ramping", int'(ramping), int'(e[2]));
        chk("timeout", int'(timeout), int'(e[1]));
        chk("src_ovr", int'(src_ovr), int'(e[0]));
        chk("dwell_state", int'(dbg_chan_dwell), int'(e[21:20]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_16mhz);
      #1;
    end
  endtask

  task automatic host_cmd(input int a, input int b);
    bit done;
    done = 1'b0;
    host_speedA = 8'(a);
    host_speedB = 8'(b);
    host_valid  = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      if (host_ready) done = 1'b1;
      cyc(1);
    end
    host_valid = 1'b0;
    chk("host_accept_bound", int'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_speedA"}, int'(speedA), 0);
    chk({tag, "_speedB"}, int'(speedB), 0);
    chk({tag, "_alive"}, int'(aliveStrobe), 0);
    chk({tag, "_ramping"}, int'(ramping), 0);
    chk({tag, "_timeout"}, int'(timeout), 1);
    chk({tag, "_src_ovr"}, int'(src_ovr), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rate;
    rst_n = 1'b0;
    host_valid = 1'b0; ovr_valid = 1'b0; estop = 1'b0;
    host_speedA = 8'sd0; host_speedB = 8'sd0; ovr_speedA = 8'sd0; ovr_speedB = 8'sd0;
    cyc(3);
    rst_n = 1'b1;
    check_reset_outputs("post_reset");

    // ramp up to +10 in steps of 4
    host_cmd(10, 0);
    cyc(20);

    // reversal from +6 to -5 through a zero dwell
    host_cmd(6, 0);
    cyc(12);
    host_cmd(-5, 0);
    cyc(36);

    // simultaneous requests: override wins, host waits
    host_speedA = 8'sd50; host_speedB = 8'sd0; host_valid = 1'b1;
    ovr_speedA = -8'sd20; ovr_speedB = 8'sd3; ovr_valid = 1'b1;
    #1;
    chk("prio_host_ready", int'(host_ready), 0);
    chk("prio_ovr_ready", int'(ovr_ready), 1);
    cyc(2);
    ovr_valid = 1'b0;
    cyc(1);
    host_valid = 1'b0;
    cyc(20);

    // watchdog trip after an idle stretch
    host_cmd(8, 0);
    cyc(100);

    // emergency stop mid-ramp, then release
    host_cmd(20, -20);
    cyc(11);
    estop = 1'b1;
    #1;
    chk("estop_host_ready", int'(host_ready), 0);
    chk("estop_ovr_ready", int'(ovr_ready), 0);
    cyc(8);
    estop = 1'b0;
    cyc(20);
    host_cmd(5, 5);
    cyc(20);

    // -128 clamp
    host_cmd(-128, 127);
    cyc(140);

    // asynchronous reset in the middle of a dwell
    host_cmd(8, 0);
    cyc(12);
    host_cmd(-8, 0);
    cyc(8);
    #1;
    chk("mid_dwell_A", int'(dbg_chan_dwell[0]), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    // randomized traffic: busy phase, then sparse phase so the watchdog trips
    for (int c = 0; c < 2400; c++) begin
      rate = (c < 1200) ? 8 : 1;
      host_valid  = ($urandom_range(0, 99) < rate);
      ovr_valid   = ($urandom_range(0, 99) < rate / 2 + 1);
      host_speedA = 8'($urandom_range(0, 255));
      host_speedB = 8'($urandom_range(0, 255));
      ovr_speedA  = 8'($urandom_range(0, 255));
      ovr_speedB  = 8'($urandom_range(0, 255));
      if (estop) estop = ($urandom_range(0, 99) >= 20);
      else       estop = ($urandom_range(0, 999) < 8);
      cyc(1);
    end
    host_valid = 1'b0; ovr_valid = 1'b0; estop = 1'b0;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sched.md
Name: motor_cmd_sched

Overview:
- Command scheduler in front of the dual-channel PWM/H-bridge driver.
- Arbitrates speed commands from two requesters: host link and override/autonomy source, with override taking priority.
- Applies per-channel slew limiting and a forced zero-dwell on direction reversal.
- Generates the driver's keep-alive strobe, runs a command watchdog and handles emergency stop.

Parameters:
RAMP_DIV, 16000, clk cycles per ramp tick (1 ms at 16 MHz); 2..65535
STEP, 4, max |speed| change per ramp tick; 1..127
DWELL_TICKS, 50, ramp ticks held at 0 before a sign reversal; 0..255
TIMEOUT_TICKS, 250, ramp ticks without an accepted command before watchdog trips; 1..65535

Ports:
clk_16mhz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
host_valid  in  1  host command valid
host_ready  out  1  host command accepted when valid&ready
host_speedA  in  8  signed target, channel A
host_speedB  in  8  signed target, channel B
ovr_valid  in  1  override command valid
ovr_ready  out  1  override accepted when valid&ready
ovr_speedA  in  8  signed target, channel A
ovr_speedB  in  8  signed target, channel B
estop  in  1  level emergency stop
speedA  out  8  signed ramped speed to driver
speedB  out  8  signed ramped speed to driver
aliveStrobe  out  1  keep-alive toggle to driver
ramping  out  1  either channel not yet at target, or in DWELL
timeout  out  1  watchdog tripped / no command since reset
src_ovr  out  1  source of last accepted command (1 = override)

Behaviour:
- Reset (async, rst_n=0): speedA/B=0, targets=0, aliveStrobe=0, ramping=0, timeout=1, src_ovr=0, channel FSMs=RUN, all counters=0.
- Ready rules (combinational):
  - ovr_ready = !estop.
  - host_ready = !estop && !ovr_valid.
  - Both valid in the same cycle: override accepted, host stalled.
- Accept: the target registers load on the accept edge (1-cycle latency).
  - -128 is clamped to -127.
  - src_ovr updates; timeout clears; watchdog counter resets to 0.
- Ramp tick: a free-running divider pulses for 1 cycle every RAMP_DIV cycles.
  - Channel updates, alive toggling and watchdog counting occur only on tick cycles.
  - A command accepted on a tick cycle takes effect on the next tick.
- Per-channel FSM, on each tick:
  - RUN, target sign opposite to a nonzero current: move current toward 0 by min(STEP, |current|). On reaching 0, enter DWELL with dwell counter = DWELL_TICKS (DWELL_TICKS=0 means skip DWELL; move toward target on the next tick).
  - RUN, otherwise: current += sign(target-current) * min(STEP, |target-current|). Use 9-bit signed math; the result never overshoots target and never leaves -127..127.
  - DWELL: output held at 0; decrement counter; at 0 return to RUN. A new target arriving during DWELL does not abort the dwell.
  - Crossing zero always passes through the value 0. The output never jumps sign in one tick.
- ramping = (speedA!=targetA) || (speedB!=targetB) || either FSM in DWELL.
- Watchdog:
  - Counts ticks while timeout=0.
  - When the count reaches TIMEOUT_TICKS, timeout=1 and both targets are forced to 0; channels ramp down normally.
  - Remains tripped until the next accepted command.
- aliveStrobe toggles on each tick when all of the following hold:
  - !estop;
  - timeout=0, or either speed is still nonzero.
  - Otherwise it holds, so the driver's own watchdog disables the bridge.
- estop=1 (level):
  - Next clk edge: speedA/B=0, targets=0, FSMs=RUN, dwell counters=0.
  - Strobe frozen; both readies low.
  - On deassert, speeds stay 0 until a new command is accepted; timeout state is unchanged by estop.
- Divider and watchdog counters saturate or wrap only as specified; there is no other wrap-around.

Test Plan:
Bench params: RAMP_DIV=4, STEP=4, DWELL_TICKS=2, TIMEOUT_TICKS=10.
- Reset, then host cmd A=+10,B=0 -> speedA steps 4,8,10 on successive ticks, holds 10; ramping falls after the third tick; timeout clears on the accept cycle.
- From speedA=+6, cmd A=-5 -> A goes 2,0, then 0 for 2 dwell ticks, then -4,-5; never goes from positive to negative without 0.
- host_valid and ovr_valid both high (host A=50, ovr A=-20) -> ovr_ready=1, host_ready=0, targetA=-20, src_ovr=1; host accepted on the cycle after ovr_valid drops.
- No command for 10 ticks after speedA=+8 -> timeout=1, A ramps 4,0; aliveStrobe toggles until A=0, then freezes.
- estop asserted mid-ramp (speedA=+12) -> speedA=speedB=0 on the next edge, both readies 0, strobe frozen; after release, speeds stay 0 until a new command is accepted.
- Command A=-128 -> targetA=-127. rst_n pulsed low mid-DWELL -> all outputs return to reset values immediately, asynchronously.
